// File: rtl/traffic_phase_sequencer.sv
// Fixed-phase intersection sequencer (LEFT -> THRU -> YELL -> WALK) with a 1 s tick and per-head countdowns.
// Optional build macro NIGHT_FLASH_EN adds the Night input and a FLASH state entered at the end of WALK.
`timescale 1ns/1ps

module traffic_phase_sequencer #(
    parameter int TSize          = 4,
    parameter int PSize          = 4,
    parameter int ClockPeriod_ns = 20,
    parameter int TickPeriod_ns  = 1_000_000_000,
    parameter int TLeft          = 5,
    parameter int TThru          = 9,
    parameter int TYellow        = 3,
    parameter int TWalk          = 7,
    parameter int SwapSec        = 3
) (
    input  logic             Clock,
    input  logic             nReset,
`ifdef NIGHT_FLASH_EN
    input  logic             Night,
`endif
    output logic [1:0]       TLight,
    output logic [1:0]       TMLight,
    output logic [1:0]       TRLight,
    output logic             PLight,
    output logic [TSize-1:0] TLsec,
    output logic [TSize-1:0] TMsec,
    output logic [TSize-1:0] TRsec,
    output logic [PSize-1:0] PLsec,
    output logic [PSize-1:0] PRsec,
    output logic             TPswitch
);

    localparam int DivN = TickPeriod_ns / ClockPeriod_ns;
    localparam int DivW = (DivN > 1) ? $clog2(DivN) : 1;
    localparam logic [DivW-1:0] DIV_LAST = DivW'((DivN > 0) ? DivN - 1 : 0);

    localparam logic [7:0] D_LEFT = 8'(TLeft);
    localparam logic [7:0] D_THRU = 8'(TThru);
    localparam logic [7:0] D_YELL = 8'(TYellow);
    localparam logic [7:0] D_WALK = 8'(TWalk);

    localparam logic [9:0] T_LEFT10 = 10'(TLeft);
    localparam logic [9:0] T_THRU10 = 10'(TThru);
    localparam logic [9:0] T_YELL10 = 10'(TYellow);
    localparam logic [9:0] T_WALK10 = 10'(TWalk);
    localparam logic [9:0] T_MAX10  = 10'((1 << TSize) - 1);
    localparam logic [9:0] P_MAX10  = 10'((1 << PSize) - 1);

    localparam bit          SWAP_EN   = (SwapSec > 0);
    localparam logic [15:0] SWAP_LAST = 16'((SwapSec > 0) ? SwapSec - 1 : 0);

    if (TLeft < 1 || TLeft > 255 || TThru < 1 || TThru > 255 ||
        TYellow < 1 || TYellow > 255 || TWalk < 1 || TWalk > 255) begin : g_bad_duration
        $error("traffic_phase_sequencer: every phase duration must be in 1..255");
    end
    if (DivN < 1) begin : g_bad_divider
        $error("traffic_phase_sequencer: TickPeriod_ns/ClockPeriod_ns must be at least 1");
    end
    if (TSize < 1 || TSize > 10 || PSize < 1 || PSize > 10) begin : g_bad_width
        $error("traffic_phase_sequencer: countdown widths must be in 1..10");
    end

    typedef enum logic [2:0] {
        PH_LEFT  = 3'd0,
        PH_THRU  = 3'd1,
        PH_YELL  = 3'd2,
`ifdef NIGHT_FLASH_EN
        PH_WALK  = 3'd3,
        PH_FLASH = 3'd4
`else
        PH_WALK  = 3'd3
`endif
    } phase_t;

    phase_t          phase_q, phase_d;
    logic [7:0]      rem_q, rem_d;
    logic [DivW-1:0] div_q, div_d;
    logic [15:0]     swap_q, swap_d;
    logic            tpsw_q, tpsw_d;
    logic            flash_q, flash_d;
    logic            tick;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d   = tick ? '0 : div_q + DivW'(1);
        phase_d = phase_q;
        rem_d   = rem_q;
        flash_d = flash_q;
        if (tick) begin
            case (phase_q)
                PH_LEFT: begin
                    if (rem_q == 8'd1) begin
                        phase_d = PH_THRU;
                        rem_d   = D_THRU;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
                PH_THRU: begin
                    if (rem_q == 8'd1) begin
                        phase_d = PH_YELL;
                        rem_d   = D_YELL;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
                PH_YELL: begin
                    if (rem_q == 8'd1) begin
                        phase_d = PH_WALK;
                        rem_d   = D_WALK;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
                PH_WALK: begin
                    if (rem_q == 8'd1) begin
                        phase_d = PH_LEFT;
                        rem_d   = D_LEFT;
`ifdef NIGHT_FLASH_EN
                        // Night is only sampled here, at the WALK -> LEFT boundary.
                        if (Night) begin
                            phase_d = PH_FLASH;
                            rem_d   = 8'd0;
                            flash_d = 1'b0;
                        end
`endif
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
`ifdef NIGHT_FLASH_EN
                PH_FLASH: begin
                    if (!Night) begin
                        phase_d = PH_LEFT;
                        rem_d   = D_LEFT;
                    end else begin
                        flash_d = ~flash_q;
                    end
                end
`endif
                default: begin
                    phase_d = PH_LEFT;
                    rem_d   = D_LEFT;
                end
            endcase
        end
    end

    always_comb begin
        swap_d = swap_q;
        tpsw_d = tpsw_q;
        if (tick && SWAP_EN) begin
            if (swap_q == SWAP_LAST) begin
                swap_d = 16'd0;
                tpsw_d = ~tpsw_q;
            end else begin
                swap_d = swap_q + 16'd1;
            end
        end
`ifdef NIGHT_FLASH_EN
        // The display selector restarts from traffic when flashing resumes normal operation.
        if (phase_d == PH_FLASH) begin
            swap_d = 16'd0;
            tpsw_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            phase_q <= PH_LEFT;
            rem_q   <= D_LEFT;
            div_q   <= '0;
            swap_q  <= 16'd0;
            tpsw_q  <= 1'b0;
            flash_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            swap_q  <= swap_d;
            tpsw_q  <= tpsw_d;
            flash_q <= flash_d;
        end
    end

    function automatic logic [TSize-1:0] sat_t(input logic [9:0] v);
        if (v > T_MAX10) return T_MAX10[TSize-1:0];
        return v[TSize-1:0];
    endfunction

    function automatic logic [PSize-1:0] sat_p(input logic [9:0] v);
        if (v > P_MAX10) return P_MAX10[PSize-1:0];
        return v[PSize-1:0];
    endfunction

    logic [9:0] rem10;
    logic [9:0] tl_sum, tm_sum, p_sum;
    logic [1:0] tl_light, tm_light;
    logic       p_light;

    assign rem10 = {2'b00, rem_q};

    // Each countdown extends through the following phases in which that head holds its state.
    always_comb begin
        tl_light = 2'b00;
        tm_light = 2'b00;
        p_light  = 1'b0;
        tl_sum   = rem10;
        tm_sum   = rem10;
        p_sum    = rem10;
        case (phase_q)
            PH_LEFT: begin
                tl_light = 2'b10;
                p_sum    = rem10 + T_THRU10 + T_YELL10;
            end
            PH_THRU: begin
                tm_light = 2'b10;
                tl_sum   = rem10 + T_YELL10 + T_WALK10;
                p_sum    = rem10 + T_YELL10;
            end
            PH_YELL: begin
                tm_light = 2'b01;
                tl_sum   = rem10 + T_WALK10;
            end
            PH_WALK: begin
                p_light = 1'b1;
                tm_sum  = rem10 + T_LEFT10;
            end
`ifdef NIGHT_FLASH_EN
            PH_FLASH: begin
                tl_light = 2'b11;
                tm_light = flash_q ? 2'b11 : 2'b01;
                tl_sum   = 10'd0;
                tm_sum   = 10'd0;
                p_sum    = 10'd0;
            end
`endif
            default: begin
                tl_light = 2'b00;
            end
        endcase
    end

    assign TLight   = tl_light;
    assign TMLight  = tm_light;
    assign TRLight  = tm_light;
    assign PLight   = p_light;
    assign TLsec    = sat_t(tl_sum);
    assign TMsec    = sat_t(tm_sum);
    assign TRsec    = sat_t(tm_sum);
    assign PLsec    = sat_p(p_sum);
    assign PRsec    = sat_p(p_sum);
    assign TPswitch = tpsw_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: per-tick vector table plus reset, saturation, swap and night-flash sequences.
`timescale 1ns/1ps

module tb_traffic_phase_sequencer;

    logic Clock;
    logic nReset;
`ifdef NIGHT_FLASH_EN
    logic Night;
`endif

    logic [1:0] TLight, TMLight, TRLight;
    logic       PLight, TPswitch;
    logic [3:0] TLsec, TMsec, TRsec, PLsec, PRsec;

    logic [1:0] s_TLight, s_TMLight, s_TRLight;
    logic       s_PLight, s_TPswitch;
    logic [2:0] s_TLsec, s_TMsec, s_TRsec, s_PLsec, s_PRsec;

    logic [1:0] z_TLight, z_TMLight, z_TRLight;
    logic       z_PLight, z_TPswitch;
    logic [3:0] z_TLsec, z_TMsec, z_TRsec, z_PLsec, z_PRsec;

    int checks = 0;
    int errors = 0;

    traffic_phase_sequencer #(
        .TSize(4), .PSize(4), .ClockPeriod_ns(20), .TickPeriod_ns(100),
        .TLeft(3), .TThru(5), .TYellow(2), .TWalk(4), .SwapSec(2)
    ) dut (
        .Clock(Clock), .nReset(nReset),
`ifdef NIGHT_FLASH_EN
        .Night(Night),
`endif
        .TLight(TLight), .TMLight(TMLight), .TRLight(TRLight), .PLight(PLight),
        .TLsec(TLsec), .TMsec(TMsec), .TRsec(TRsec), .PLsec(PLsec), .PRsec(PRsec),
        .TPswitch(TPswitch)
    );

    traffic_phase_sequencer #(
        .TSize(3), .PSize(3), .ClockPeriod_ns(20), .TickPeriod_ns(100),
        .TLeft(3), .TThru(5), .TYellow(2), .TWalk(4), .SwapSec(2)
    ) dut_sat (
        .Clock(Clock), .nReset(nReset),
`ifdef NIGHT_FLASH_EN
        .Night(Night),
`endif
        .TLight(s_TLight), .TMLight(s_TMLight), .TRLight(s_TRLight), .PLight(s_PLight),
        .TLsec(s_TLsec), .TMsec(s_TMsec), .TRsec(s_TRsec), .PLsec(s_PLsec), .PRsec(s_PRsec),
        .TPswitch(s_TPswitch)
    );

    traffic_phase_sequencer #(
        .TSize(4), .PSize(4), .ClockPeriod_ns(20), .TickPeriod_ns(100),
        .TLeft(3), .TThru(5), .TYellow(2), .TWalk(4), .SwapSec(0)
    ) dut_noswap (
        .Clock(Clock), .nReset(nReset),
`ifdef NIGHT_FLASH_EN
        .Night(Night),
`endif
        .TLight(z_TLight), .TMLight(z_TMLight), .TRLight(z_TRLight), .PLight(z_PLight),
        .TLsec(z_TLsec), .TMsec(z_TMsec), .TRsec(z_TRsec), .PLsec(z_PLsec), .PRsec(z_PRsec),
        .TPswitch(z_TPswitch)
    );

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    typedef struct {
        logic [1:0] tl;
        logic [1:0] tm;
        logic       p;
        int         tls;
        int         tms;
        int         pls;
        logic       tp;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int min7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    task automatic ticks(input int n);
        repeat (5 * n) @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic pulse_reset();
        @(negedge Clock);
        nReset = 1'b0;
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    initial begin
        // State after k ticks: LEFT3 / THRU5 / YELL2 / WALK4, TPswitch toggling every 2nd tick.
        vecs[0]  = '{2'd2, 2'd0, 1'b0,  3, 3, 10, 1'b0};
        vecs[1]  = '{2'd2, 2'd0, 1'b0,  2, 2,  9, 1'b0};
        vecs[2]  = '{2'd2, 2'd0, 1'b0,  1, 1,  8, 1'b1};
        vecs[3]  = '{2'd0, 2'd2, 1'b0, 11, 5,  7, 1'b1};
        vecs[4]  = '{2'd0, 2'd2, 1'b0, 10, 4,  6, 1'b0};
        vecs[5]  = '{2'd0, 2'd2, 1'b0,  9, 3,  5, 1'b0};
        vecs[6]  = '{2'd0, 2'd2, 1'b0,  8, 2,  4, 1'b1};
        vecs[7]  = '{2'd0, 2'd2, 1'b0,  7, 1,  3, 1'b1};
        vecs[8]  = '{2'd0, 2'd1, 1'b0,  6, 2,  2, 1'b0};
        vecs[9]  = '{2'd0, 2'd1, 1'b0,  5, 1,  1, 1'b0};
        vecs[10] = '{2'd0, 2'd0, 1'b1,  4, 7,  4, 1'b1};
        vecs[11] = '{2'd0, 2'd0, 1'b1,  3, 6,  3, 1'b1};
        vecs[12] = '{2'd0, 2'd0, 1'b1,  2, 5,  2, 1'b0};
        vecs[13] = '{2'd0, 2'd0, 1'b1,  1, 4,  1, 1'b0};
        vecs[14] = '{2'd2, 2'd0, 1'b0,  3, 3, 10, 1'b1};

        nReset = 1'b0;
`ifdef NIGHT_FLASH_EN
        Night = 1'b0;
`endif
        repeat (3) @(negedge Clock);

        check("rst_TLight", TLight, 2);
        check("rst_TMLight", TMLight, 0);
        check("rst_TRLight", TRLight, 0);
        check("rst_PLight", PLight, 0);
        check("rst_TLsec", TLsec, 3);
        check("rst_TMsec", TMsec, 3);
        check("rst_PLsec", PLsec, 10);
        check("rst_PRsec", PRsec, 10);
        check("rst_TPswitch", TPswitch, 0);
        check("rst_sat_PLsec", s_PLsec, 7);
        check("rst_sat_PRsec", s_PRsec, 7);
        $display("reset: TLight=%0d TLsec=%0d PLsec=%0d sat_PLsec=%0d", TLight, TLsec, PLsec, s_PLsec);

        nReset = 1'b1;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("pre_first_tick_TLsec", TLsec, 3);
        @(posedge Clock);
        @(negedge Clock);
        check("first_tick_TLsec", TLsec, 2);
        $display("first tick: TLsec=%0d after 5 clocks", TLsec);

        pulse_reset();
        for (int k = 0; k < 15; k++) begin
            if (k > 0) ticks(1);
            check($sformatf("v%0d_TLight", k), TLight, vecs[k].tl);
            check($sformatf("v%0d_TMLight", k), TMLight, vecs[k].tm);
            check($sformatf("v%0d_TRLight", k), TRLight, vecs[k].tm);
            check($sformatf("v%0d_PLight", k), PLight, vecs[k].p);
            check($sformatf("v%0d_TLsec", k), TLsec, vecs[k].tls);
            check($sformatf("v%0d_TMsec", k), TMsec, vecs[k].tms);
            check($sformatf("v%0d_TRsec", k), TRsec, vecs[k].tms);
            check($sformatf("v%0d_PLsec", k), PLsec, vecs[k].pls);
            check($sformatf("v%0d_PRsec", k), PRsec, vecs[k].pls);
            check($sformatf("v%0d_TPswitch", k), TPswitch, vecs[k].tp);
            check($sformatf("v%0d_sat_TLsec", k), s_TLsec, min7(vecs[k].tls));
            check($sformatf("v%0d_sat_PLsec", k), s_PLsec, min7(vecs[k].pls));
            check($sformatf("v%0d_noswap_TP", k), z_TPswitch, 0);
            $display("tick %0d: TL=%0d TM=%0d P=%0d TLsec=%0d TMsec=%0d PLsec=%0d TP=%0d",
                     k, TLight, TMLight, PLight, TLsec, TMsec, PLsec, TPswitch);
        end

        // Asynchronous reset landing on the third clock of YELL.
        pulse_reset();
        repeat (42) @(posedge Clock);
        #2;
        check("yell_before_reset_TMLight", TMLight, 1);
        #1;
        nReset = 1'b0;
        #1;
        check("async_rst_TLight", TLight, 2);
        check("async_rst_TMLight", TMLight, 0);
        check("async_rst_TLsec", TLsec, 3);
        check("async_rst_PLsec", PLsec, 10);
        repeat (7) @(posedge Clock);
        #1;
        check("held_rst_TLsec", TLsec, 3);
        @(negedge Clock);
        nReset = 1'b1;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("after_rst_pre_tick_TLsec", TLsec, 3);
        @(posedge Clock);
        @(negedge Clock);
        check("after_rst_tick_TLsec", TLsec, 2);
        $display("mid-YELL reset: resumed LEFT, TLsec=%0d after 5 clocks", TLsec);

`ifdef NIGHT_FLASH_EN
        pulse_reset();
        Night = 1'b1;
        ticks(3);
        check("night_ignored_THRU_TMLight", TMLight, 2);
        ticks(11);
        check("flash0_TLight", TLight, 3);
        check("flash0_TMLight", TMLight, 1);
        check("flash0_TRLight", TRLight, 1);
        check("flash0_PLight", PLight, 0);
        check("flash0_TLsec", TLsec, 0);
        check("flash0_TMsec", TMsec, 0);
        check("flash0_PLsec", PLsec, 0);
        check("flash0_TPswitch", TPswitch, 0);
        $display("flash tick 14: TL=%0d TM=%0d TP=%0d", TLight, TMLight, TPswitch);
        ticks(1);
        check("flash1_TMLight", TMLight, 3);
        $display("flash tick 15: TM=%0d", TMLight);
        ticks(1);
        check("flash2_TMLight", TMLight, 1);
        check("flash2_TPswitch", TPswitch, 0);
        $display("flash tick 16: TM=%0d", TMLight);
        Night = 1'b0;
        ticks(1);
        check("unflash_TLight", TLight, 2);
        check("unflash_TMLight", TMLight, 0);
        check("unflash_TLsec", TLsec, 3);
        ticks(1);
        check("unflash_next_TLsec", TLsec, 2);
        $display("night off: TL=%0d TLsec=%0d", TLight, TLsec);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
